// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction
// fetch and load/store, with a fixed response latency per access.
module memory_arbiter #(
   parameter int RegBits       = 32,
   parameter int LatencyCycles = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               if_req_i,
   input  logic [RegBits-1:0] if_addr_i,
   output logic               if_gnt_o,
   output logic               if_rvalid_o,
   output logic [RegBits-1:0] if_rdata_o,
   input  logic               dm_req_i,
   input  logic [RegBits-1:0] dm_addr_i,
   input  logic [RegBits-1:0] dm_wdata_i,
   input  logic [1:0]         dm_we_i,
   output logic               dm_gnt_o,
   output logic               dm_rvalid_o,
   output logic [RegBits-1:0] dm_rdata_o,
   output logic               mem_req_o,
   output logic [RegBits-1:0] mem_addr_o,
   output logic [RegBits-1:0] mem_wdata_o,
   output logic [1:0]         mem_we_o,
   input  logic [RegBits-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

   localparam logic [3:0] CntLoad = 4'(LatencyCycles - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       last_dm_q, last_dm_d;
   logic       store_q, store_d;
   logic       slot, done, pick_if, pick_dm;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         last_dm_q <= 1'b1;
         store_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_dm_q <= last_dm_d;
         store_q   <= store_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_dm_d   = last_dm_q;
      store_d     = store_q;
      if_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      dm_gnt_o    = 1'b0;
      dm_rvalid_o = 1'b0;
      dm_rdata_o  = '0;
      mem_req_o   = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_we_o    = 2'b00;
      done        = (state_q != IDLE) && (cnt_q == 4'd0);
      slot        = (state_q == IDLE) || (cnt_q == 4'd0);
      // On a tie the side that did not win last time goes first
      pick_if     = slot && if_req_i && (!dm_req_i || last_dm_q);
      pick_dm     = slot && dm_req_i && !pick_if;
      if (!rst_i) begin
         if (done) begin
            state_d = IDLE;
            if (state_q == BUSY_IF) begin
               if_rvalid_o = 1'b1;
               if_rdata_o  = mem_rdata_i;
            end else begin
               dm_rvalid_o = 1'b1;
               dm_rdata_o  = store_q ? '0 : mem_rdata_i;
            end
         end else if (state_q != IDLE) begin
            cnt_d = cnt_q - 4'd1;
         end
         if (pick_if) begin
            if_gnt_o   = 1'b1;
            mem_req_o  = 1'b1;
            mem_addr_o = if_addr_i;
            state_d    = BUSY_IF;
            cnt_d      = CntLoad;
            last_dm_d  = 1'b0;
         end else if (pick_dm) begin
            dm_gnt_o    = 1'b1;
            mem_req_o   = 1'b1;
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
            mem_we_o    = dm_we_i;
            state_d     = BUSY_DM;
            cnt_d       = CntLoad;
            last_dm_d   = 1'b1;
            store_d     = (dm_we_i != 2'b00);
         end
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: latency-2 and latency-1 instances share stimulus
// and are checked each cycle against a due-time model plus directed literals.
module tb_memory_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        dm_req = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [1:0]  dm_we = '0;
   int          cyc = 0;
   logic [31:0] mrd;

   logic [1:0]  if_gnt, if_rv, dm_gnt, dm_rv, mreq;
   logic [31:0] if_rd [2];
   logic [31:0] dm_rd [2];
   logic [31:0] maddr [2];
   logic [31:0] mwd   [2];
   logic [1:0]  mwe   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   // Memory read data is tagged with the cycle it is presented in
   assign mrd = 32'hA500_0000 | 32'(cyc);

   memory_arbiter #(.RegBits(32), .LatencyCycles(2)) u_l2 (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr),
      .if_gnt_o(if_gnt[0]), .if_rvalid_o(if_rv[0]), .if_rdata_o(if_rd[0]),
      .dm_req_i(dm_req), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_we_i(dm_we),
      .dm_gnt_o(dm_gnt[0]), .dm_rvalid_o(dm_rv[0]), .dm_rdata_o(dm_rd[0]),
      .mem_req_o(mreq[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwd[0]),
      .mem_we_o(mwe[0]), .mem_rdata_i(mrd)
   );

   memory_arbiter #(.RegBits(32), .LatencyCycles(1)) u_l1 (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr),
      .if_gnt_o(if_gnt[1]), .if_rvalid_o(if_rv[1]), .if_rdata_o(if_rd[1]),
      .dm_req_i(dm_req), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_we_i(dm_we),
      .dm_gnt_o(dm_gnt[1]), .dm_rvalid_o(dm_rv[1]), .dm_rdata_o(dm_rd[1]),
      .mem_req_o(mreq[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwd[1]),
      .mem_we_o(mwe[1]), .mem_rdata_i(mrd)
   );

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic check_dut(int i, logic ig, logic irv, logic [31:0] ird,
                            logic dg, logic drv, logic [31:0] drd,
                            logic mq, logic [31:0] ma, logic [31:0] mw,
                            logic [1:0] mw_e);
      string p;
      p = (i == 0) ? "L2" : "L1";
      chk({p, " if_gnt"},    32'(if_gnt[i]), 32'(ig));
      chk({p, " if_rvalid"}, 32'(if_rv[i]),  32'(irv));
      chk({p, " if_rdata"},  if_rd[i],       ird);
      chk({p, " dm_gnt"},    32'(dm_gnt[i]), 32'(dg));
      chk({p, " dm_rvalid"}, 32'(dm_rv[i]),  32'(drv));
      chk({p, " dm_rdata"},  dm_rd[i],       drd);
      chk({p, " mem_req"},   32'(mreq[i]),   32'(mq));
      chk({p, " mem_addr"},  maddr[i],       ma);
      chk({p, " mem_wdata"}, mwd[i],         mw);
      chk({p, " mem_we"},    32'(mwe[i]),    32'(mw_e));
   endtask

   // Model: one pending access per instance, answered at its due cycle
   bit busy [2];
   int due  [2];
   bit sdm  [2];
   bit sst  [2];
   bit ldm  [2];
   int lat  [2] = '{2, 1};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic resp, free, gi, gd;
         if (rst) begin
            check_dut(i, 0, 0, '0, 0, 0, '0, 0, '0, '0, 2'b00);
            busy[i] = 1'b0;
            ldm[i]  = 1'b1;
         end else begin
            resp = busy[i] && (due[i] == cyc);
            free = !busy[i] || resp;
            gi   = free && if_req && (!dm_req || ldm[i]);
            gd   = free && dm_req && !gi;
            check_dut(i,
               gi, resp && !sdm[i], (resp && !sdm[i]) ? mrd : 32'h0,
               gd, resp && sdm[i],
               (resp && sdm[i] && !sst[i]) ? mrd : 32'h0,
               gi || gd,
               gi ? if_addr : (gd ? dm_addr : 32'h0),
               gd ? dm_wdata : 32'h0,
               gd ? dm_we : 2'b00);
            if (resp) busy[i] = 1'b0;
            if (gi || gd) begin
               busy[i] = 1'b1;
               due[i]  = cyc + lat[i];
               sdm[i]  = gd;
               sst[i]  = gd && (dm_we != 2'b00);
               ldm[i]  = gd;
            end
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      dm_we    = 2'b00;
      next();
      next();
      rst = 1'b0;
   endtask

   initial begin
      // Single fetch; request held high through reset
      #1;
      rst     = 1'b1;
      if_req  = 1'b1;
      if_addr = 32'h10;
      next();
      neg();
      chk("rst if_gnt", 32'(if_gnt[0]), 32'd0);
      chk("rst mem_req", 32'(mreq[0]), 32'd0);
      next();
      rst = 1'b0;
      neg();
      chk("s1 c0 if_gnt", 32'(if_gnt[0]), 32'd1);
      chk("s1 c0 mem_addr", maddr[0], 32'h10);
      chk("s1 c0 mem_we", 32'(mwe[0]), 32'd0);
      next();
      if_req = 1'b0;
      neg();
      chk("s1 c1 l1 if_rvalid", 32'(if_rv[1]), 32'd1);
      chk("s1 c1 l1 if_rdata", if_rd[1], 32'hA500_0001);
      chk("s1 c1 if_rvalid", 32'(if_rv[0]), 32'd0);
      next();
      neg();
      chk("s1 c2 if_rvalid", 32'(if_rv[0]), 32'd1);
      chk("s1 c2 if_rdata", if_rd[0], 32'hA500_0002);
      next();
      next();

      // Word store
      do_reset();
      dm_req   = 1'b1;
      dm_we    = 2'b11;
      dm_addr  = 32'h40;
      dm_wdata = 32'hDEAD_BEEF;
      neg();
      chk("s2 c0 dm_gnt", 32'(dm_gnt[0]), 32'd1);
      chk("s2 c0 mem_we", 32'(mwe[0]), 32'd3);
      chk("s2 c0 mem_wdata", mwd[0], 32'hDEAD_BEEF);
      next();
      dm_req = 1'b0;
      dm_we  = 2'b00;
      next();
      neg();
      chk("s2 c2 dm_rvalid", 32'(dm_rv[0]), 32'd1);
      chk("s2 c2 dm_rdata", dm_rd[0], 32'h0);
      next();
      next();

      // Sustained contention from reset
      do_reset();
      if_req   = 1'b1;
      if_addr  = 32'h100;
      dm_req   = 1'b1;
      dm_addr  = 32'h200;
      dm_wdata = 32'h1234_5678;
      dm_we    = 2'b00;
      for (int c = 0; c < 9; c++) begin
         neg();
         if (c % 2 == 0) begin
            chk("s3 if_gnt", 32'(if_gnt[0]), 32'(c % 4 == 0));
            chk("s3 dm_gnt", 32'(dm_gnt[0]), 32'(c % 4 == 2));
         end
         if (c >= 2 && c % 2 == 0) begin
            chk("s3 if_rvalid", 32'(if_rv[0]), 32'(c % 4 == 2));
            chk("s3 dm_rvalid", 32'(dm_rv[0]), 32'(c % 4 == 0));
         end
         if (c == 4) chk("s3 c4 dm_rdata", dm_rd[0], 32'hA500_0004);
         next();
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      next();
      next();

      // Data request arriving while a fetch is in flight
      do_reset();
      if_req  = 1'b1;
      if_addr = 32'h20;
      neg();
      chk("s4 c0 if_gnt", 32'(if_gnt[0]), 32'd1);
      next();
      if_req   = 1'b0;
      dm_req   = 1'b1;
      dm_addr  = 32'h60;
      dm_we    = 2'b10;
      dm_wdata = 32'h0000_CAFE;
      neg();
      chk("s4 c1 dm_gnt", 32'(dm_gnt[0]), 32'd0);
      next();
      neg();
      chk("s4 c2 dm_gnt", 32'(dm_gnt[0]), 32'd1);
      chk("s4 c2 if_rvalid", 32'(if_rv[0]), 32'd1);
      next();
      dm_req = 1'b0;
      dm_we  = 2'b00;
      next();
      next();
      next();

      // Reset in the middle of a load
      do_reset();
      dm_req  = 1'b1;
      dm_addr = 32'h80;
      neg();
      chk("s5 c0 dm_gnt", 32'(dm_gnt[0]), 32'd1);
      next();
      dm_req = 1'b0;
      rst    = 1'b1;
      neg();
      chk("s5 abort dm_rvalid", 32'(dm_rv[0]), 32'd0);
      next();
      rst     = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h30;
      neg();
      chk("s5 release if_gnt", 32'(if_gnt[0]), 32'd1);
      chk("s5 release dm_rvalid", 32'(dm_rv[0]), 32'd0);
      next();
      if_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         neg();
         chk("s5 late dm_rvalid", 32'(dm_rv[0]), 32'd0);
         next();
      end

      // Latency 1: back-to-back data loads
      do_reset();
      dm_req  = 1'b1;
      dm_addr = 32'h90;
      for (int c = 0; c < 5; c++) begin
         if (c == 4) dm_req = 1'b0;
         neg();
         chk("s6 l1 dm_gnt", 32'(dm_gnt[1]), 32'(c < 4));
         chk("s6 l1 dm_rvalid", 32'(dm_rv[1]), 32'(c >= 1));
         next();
      end
      next();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
